// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter: frame width, default sclk
// dividers, FSM state encoding and the half-period counter width helper.
package dac_spi_tx_pkg;

    localparam int DAC_DW       = 16;
    localparam int DIV_FAST_DEF = 1;
    localparam int DIV_SLOW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // One extra bit above clog2 so the largest divider value itself fits.
    function automatic int half_cnt_w(input int div_a, input int div_b);
        return $clog2((div_a > div_b) ? div_a : div_b) + 1;
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample-side handshake of the DAC SPI transmitter: the producer (mixer) is
// the master, the transmitter is the slave.
interface dac_spi_tx_if
    import dac_spi_tx_pkg::*;
#(
    parameter int DW = DAC_DW
) ();

    logic [DW-1:0] sample_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic          speed_sel_i;

    modport master (
        output sample_i,
        output sample_valid_i,
        output speed_sel_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        input  speed_sel_i,
        output sample_ready_o
    );

endinterface

// File: rtl/dac_sclk_div.sv
// Loadable half-period counter: after a load with H it emits a one-cycle tick
// on the last cycle of every H-cycle window while enabled.
module dac_sclk_div
    import dac_spi_tx_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [CW-1:0] half_i,
    output logic          tick_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_q, half_d;
    logic          wrap;

    assign wrap   = (cnt_q == half_q - CW'(1));
    assign tick_o = en_i & wrap;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (load_i) begin
            cnt_d  = '0;
            half_d = half_i;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            half_q <= CW'(1);
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master framing one DW-bit sample MSB-first to the DAC (CPOL=0, DAC
// samples on sclk fall). Optional one-entry input buffer: DAC_SPI_TX_DBUF_EN.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int DW       = DAC_DW,
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int DIV_SLOW = DIV_SLOW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dac_spi_tx_if.slave        s_if,
    output logic               dac_csb_o,
    output logic               dac_sclk_o,
    output logic               dac_mosi_o,
    output logic               frame_done_o
);

    localparam int              CW     = half_cnt_w(DIV_FAST, DIV_SLOW);
    localparam int              BW     = $clog2(DW + 1);
    localparam logic [CW-1:0]   H_FAST = CW'(DIV_FAST);
    localparam logic [CW-1:0]   H_SLOW = CW'(DIV_SLOW);
    localparam logic [BW-1:0]   BITS   = BW'(DW);

    state_e        state_q, state_d;
    logic          csb_q, csb_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ready_q, ready_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    logic          accept;
    logic          tick;
    logic          start;
    logic [DW-1:0] start_sample;
    logic          start_fast;
    logic          div_load;
    logic [CW-1:0] div_half;

    assign accept = s_if.sample_valid_i & ready_q;

`ifdef DAC_SPI_TX_DBUF_EN
    logic [DW-1:0] buf_q, buf_d;
    logic          buf_fast_q, buf_fast_d;
    logic          buf_valid_q, buf_valid_d;
    logic          start_point;

    // A frame may begin from IDLE or straight out of GAP; a buffered sample
    // always goes first, otherwise an accept this cycle bypasses the buffer.
    always_comb begin
        start_point  = (state_q == ST_IDLE) | ((state_q == ST_GAP) & tick);
        start        = start_point & (buf_valid_q | accept);
        start_sample = buf_valid_q ? buf_q : s_if.sample_i;
        start_fast   = buf_valid_q ? buf_fast_q : s_if.speed_sel_i;
        buf_d        = buf_q;
        buf_fast_d   = buf_fast_q;
        buf_valid_d  = buf_valid_q;
        if (start & buf_valid_q)
            buf_valid_d = 1'b0;
        if (accept & ~(start & ~buf_valid_q)) begin
            buf_d       = s_if.sample_i;
            buf_fast_d  = s_if.speed_sel_i;
            buf_valid_d = 1'b1;
        end
    end

    assign ready_d = ~buf_valid_d;

    // NOTE: data-only registers are reset too; it is cheap at this size and
    // keeps every pin and stored value deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            buf_fast_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_fast_q  <= buf_fast_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`else
    always_comb begin
        start        = (state_q == ST_IDLE) & accept;
        start_sample = s_if.sample_i;
        start_fast   = s_if.speed_sel_i;
    end

    assign ready_d = (state_d == ST_IDLE);
`endif

    dac_sclk_div #(
        .CW (CW)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != ST_IDLE),
        .load_i (div_load),
        .half_i (div_half),
        .tick_o (tick)
    );

    // Every phase lasts one divider window; tick marks its last cycle.
    always_comb begin
        state_d      = state_q;
        csb_d        = csb_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        frame_done_d = 1'b0;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_load     = 1'b0;
        div_half     = start_fast ? H_FAST : H_SLOW;

        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    mosi_d  = shreg_q[DW-1];
                    shreg_d = {shreg_q[DW-2:0], 1'b0};
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q - BW'(1);
                    end else if (bit_cnt_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d  = 1'b1;
                        mosi_d  = shreg_q[DW-1];
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d      = ST_GAP;
                    csb_d        = 1'b1;
                    mosi_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d   = ST_SETUP;
            csb_d     = 1'b0;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            shreg_d   = start_sample;
            bit_cnt_d = BITS;
            div_load  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            csb_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            csb_q        <= csb_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign s_if.sample_ready_o = ready_q;
    assign dac_csb_o           = csb_q;
    assign dac_sclk_o          = sclk_q;
    assign dac_mosi_o          = mosi_q;
    assign frame_done_o        = frame_done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: a DAC model reassembles each frame from
// the pins and a monitor compares it with the queue of expected frames.
`timescale 1ns/1ps
module tb_dac_spi_tx;
    import dac_spi_tx_pkg::*;

    localparam int DW       = 16;
    localparam int DIV_FAST = 1;
    localparam int DIV_SLOW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic csb, sclk, mosi, frame_done;

    dac_spi_tx_if #(.DW(DW)) s_if ();

    dac_spi_tx #(
        .DW       (DW),
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_if         (s_if),
        .dac_csb_o    (csb),
        .dac_sclk_o   (sclk),
        .dac_mosi_o   (mosi),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            h;
    } frame_t;

    frame_t exp_q[$];
    int n_cmp = 0, n_err = 0;
    int n_sent = 0, n_frames = 0, n_aborted = 0;
    int last_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference rules, straight from the frame timing definition.
    function automatic int half_of(input bit fast);
        return fast ? DIV_FAST : DIV_SLOW;
    endfunction

    function automatic int accept_period(input int h);
        return (2 * DW + 3) * h + 1;
    endfunction

    function automatic int csb_low_cycles(input int h);
        return (2 * DW + 2) * h;
    endfunction

    // DAC model + scoreboard monitor; samples pins on the falling clk edge.
    initial begin : monitor
        logic          p_csb;
        logic          p_sclk;
        logic [DW-1:0] dac_sr;
        int            run_len, low_cyc, hi_len, falls, bad_runs, cur_h;
        bit            have_exp, rise;
        frame_t        f;
        p_csb = 1'b1; p_sclk = 1'b0; dac_sr = '0;
        run_len = 0; low_cyc = 0; hi_len = 0; falls = 0; bad_runs = 0; cur_h = 0;
        have_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_csb = 1'b1; p_sclk = 1'b0; hi_len = 0; falls = 0; have_exp = 1'b0;
            end else begin
                rise = csb && !p_csb;
                if (frame_done || rise)
                    check("frame_done_pulse", frame_done, rise);
                if (!csb && p_csb) begin
                    last_gap = hi_len;
                    low_cyc = 1; falls = 0; bad_runs = 0; run_len = 1; dac_sr = '0;
                    have_exp = exp_q.size() > 0;
                    cur_h = have_exp ? exp_q[0].h : 0;
                end else if (!csb) begin
                    low_cyc++;
                    if (sclk == p_sclk) begin
                        run_len++;
                    end else begin
                        if (run_len != cur_h) bad_runs++;
                        if (!sclk) begin
                            falls++;
                            dac_sr = {dac_sr[DW-2:0], mosi};
                        end
                        run_len = 1;
                    end
                end else if (rise) begin
                    check("frame_expected", have_exp, 1'b1);
                    if (have_exp) begin
                        f = exp_q.pop_front();
                        check("captured_data", dac_sr, f.data);
                        check("sclk_falls", falls, DW);
                        check("csb_low_cycles", low_cyc, csb_low_cycles(f.h));
                        check("bad_half_periods", bad_runs, 0);
                        n_frames++;
                    end
                    have_exp = 1'b0;
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
                p_csb = csb;
                p_sclk = sclk;
            end
        end
    end

    // Called at a falling clk edge; returns at the falling edge after accept.
    task automatic send(input logic [DW-1:0] d, input bit fast, input bit keep, output int acc);
        int w;
        frame_t f;
        w = 0;
        s_if.sample_i       = d;
        s_if.speed_sel_i    = fast;
        s_if.sample_valid_i = 1'b1;
        while (s_if.sample_ready_o !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (s_if.sample_ready_o !== 1'b1) begin
            check("accept_timeout", 1'b0, 1'b1);
            s_if.sample_valid_i = 1'b0;
        end else begin
            f.data = d;
            f.h    = half_of(fast);
            exp_q.push_back(f);
            n_sent++;
            @(posedge clk);
            @(negedge clk);
            if (!keep) s_if.sample_valid_i = 1'b0;
        end
    endtask

    task automatic wait_ready(output int c);
        int w;
        w = 0;
        while (s_if.sample_ready_o !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        c = cyc;
        if (s_if.sample_ready_o !== 1'b1) check("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || csb !== 1'b1) && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a, b, r;
        logic [DW-1:0] d;
        s_if.sample_i       = '0;
        s_if.sample_valid_i = 1'b0;
        s_if.speed_sel_i    = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_csb", csb, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ready", s_if.sample_ready_o, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        #1 check("ready_before_first_clk", s_if.sample_ready_o, 1'b0);
        @(negedge clk);
        check("ready_after_release", s_if.sample_ready_o, 1'b1);

        send(16'hA5C3, 1'b1, 1'b0, a);
`ifndef DAC_SPI_TX_DBUF_EN
        wait_ready(r);
        check("latency_fast", r - a, accept_period(DIV_FAST));
`else
        check("ready_during_frame", s_if.sample_ready_o, 1'b1);
`endif
        wait_drain();

        send(16'h0001, 1'b0, 1'b0, a);
`ifndef DAC_SPI_TX_DBUF_EN
        wait_ready(r);
        check("latency_slow", r - a, accept_period(DIV_SLOW));
`endif
        wait_drain();

        send(16'h1234, 1'b1, 1'b1, a);
        send(16'hFFFF, 1'b1, 1'b0, b);
        wait_drain();
`ifndef DAC_SPI_TX_DBUF_EN
        check("b2b_accept_spacing", b - a, accept_period(DIV_FAST));
        check("b2b_csb_high", last_gap, DIV_FAST + 1);
`else
        check("b2b_accept_in_frame", (b - a) < accept_period(DIV_FAST), 1'b1);
        check("b2b_csb_high", last_gap, DIV_FAST);
`endif

        send(16'h8000, 1'b1, 1'b0, a);
        repeat (10) @(negedge clk);
        s_if.speed_sel_i = 1'b0;
        wait_drain();
        s_if.speed_sel_i = 1'b1;

        // Abort during bit 7 (sclk high); bit 7 of the frame is sample[8].
        d = DW'($urandom) | 16'h0100;
        send(d, 1'b1, 1'b0, a);
        repeat (15) @(negedge clk);
        check("pre_abort_sclk_high", sclk, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_csb", csb, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        exp_q.delete();
        n_aborted++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_ready_at_release", s_if.sample_ready_o, 1'b0);
        @(negedge clk);
        check("abort_ready_one_clk", s_if.sample_ready_o, 1'b1);

        for (int i = 0; i < 16; i++) begin
            d = DW'($urandom);
            send(d, 1'($urandom_range(0, 1)), 1'b0, a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

        check("frames_captured", n_frames, n_sent - n_aborted);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
